mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the combinational ALU in the EX stage and executes mult, multu, div, divu, mthi and mtlo. It models a fixed, parametrised latency and raises a stall request so the hazard unit can hold dependent instructions. Operand width and per-class latency are parameters, so the same block serves narrower test builds.

---
 rtl/mult_div_unit.sv | 186 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Fixed latency per class. Results commit on the last busy edge.
module mult_div_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef enum logic [1:0] {
      K_MULT,
      K_MULTU,
      K_DIV,
      K_DIVU
   } kind_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   kind_t            kind_q, kind_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             is_md;
   logic             sgn;
   logic             neg_a;
   logic             neg_b;
   logic             is_div;
   logic             dz;
   logic [WIDTH-1:0] ua, ub;
   logic [WIDTH-1:0] uq, ur;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] res_hi, res_lo;

   always_comb begin
      is_md = (op == OP_MULT) || (op == OP_MULTU) ||
              (op == OP_DIV)  || (op == OP_DIVU);
   end

   // Signed ops run on magnitudes, then fix signs; min/-1 wraps naturally.
   always_comb begin
      sgn    = (kind_q == K_MULT) || (kind_q == K_DIV);
      is_div = (kind_q == K_DIV) || (kind_q == K_DIVU);
      neg_a  = sgn & a_q[WIDTH-1];
      neg_b  = sgn & b_q[WIDTH-1];
      ua     = neg_a ? -a_q : a_q;
      ub     = neg_b ? -b_q : b_q;
      dz     = is_div && (b_q == '0);
      prod   = {{WIDTH{1'b0}}, ua} * {{WIDTH{1'b0}}, ub};
      if (neg_a ^ neg_b) begin
         prod = -prod;
      end
      uq = '0;
      ur = ua;
      if (ub != '0) begin
         uq = ua / ub;
         ur = ua % ub;
      end
      if (neg_a ^ neg_b) begin
         uq = -uq;
      end
      if (neg_a) begin
         ur = -ur;
      end
      if (is_div) begin
         res_hi = ur;
         res_lo = uq;
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     state_d = RUN;
                     kind_d  = K_MULT;
                     cnt_d   = CW'(MULT_CYCLES);
                     a_d     = rs_val;
                     b_d     = rt_val;
                  end
                  OP_MULTU: begin
                     state_d = RUN;
                     kind_d  = K_MULTU;
                     cnt_d   = CW'(MULT_CYCLES);
                     a_d     = rs_val;
                     b_d     = rt_val;
                  end
                  OP_DIV: begin
                     state_d = RUN;
                     kind_d  = K_DIV;
                     cnt_d   = CW'(DIV_CYCLES);
                     a_d     = rs_val;
                     b_d     = rt_val;
                  end
                  OP_DIVU: begin
                     state_d = RUN;
                     kind_d  = K_DIVU;
                     cnt_d   = CW'(DIV_CYCLES);
                     a_d     = rs_val;
                     b_d     = rt_val;
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               if (!dz) begin
                  hi_d = res_hi;
                  lo_d = res_lo;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         kind_q  <= K_MULT;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign stall = busy | (start & is_md);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle model plus directed vectors.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   int busy_cyc  = 0;
   int stall_cyc = 0;

   int          m_cnt = 0;
   bit          m_commit = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] p_hi = 32'd0;
   logic [31:0] p_lo = 32'd0;
   longint          sa, sb, sr;
   longint unsigned ua, ub, ur;

   mult_div_unit #(
      .WIDTH(32),
      .MULT_CYCLES(5),
      .DIV_CYCLES(10)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .op(op),
      .rs_val(rs_val),
      .rt_val(rt_val),
      .busy(busy),
      .stall(stall),
      .hi(hi),
      .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural model: plain 64-bit arithmetic on sampled inputs.
   always @(posedge clk) begin
      if (!reset_n) begin
         m_cnt = 0;
         m_hi  = 32'd0;
         m_lo  = 32'd0;
      end else if (m_cnt != 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0 && m_commit) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (start) begin
         sa = longint'($signed(rs_val));
         sb = longint'($signed(rt_val));
         ua = longint'(rs_val);
         ub = longint'(rt_val);
         m_commit = 1'b1;
         case (op)
            4'd1: begin
               sr = sa * sb;
               p_hi = sr[63:32];
               p_lo = sr[31:0];
               m_cnt = 5;
            end
            4'd2: begin
               ur = ua * ub;
               p_hi = ur[63:32];
               p_lo = ur[31:0];
               m_cnt = 5;
            end
            4'd3: begin
               m_cnt = 10;
               if (sb == 0) m_commit = 1'b0;
               else begin
                  sr = sa / sb;
                  p_lo = sr[31:0];
                  sr = sa % sb;
                  p_hi = sr[31:0];
               end
            end
            4'd4: begin
               m_cnt = 10;
               if (ub == 0) m_commit = 1'b0;
               else begin
                  ur = ua / ub;
                  p_lo = ur[31:0];
                  ur = ua % ub;
                  p_hi = ur[31:0];
               end
            end
            4'd5: m_hi = rs_val;
            4'd6: m_lo = rs_val;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
         check("stall", {31'b0, stall},
               {31'b0, (m_cnt != 0) ||
                       (start && op >= 4'd1 && op <= 4'd4)});
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
      end
      if (busy) busy_cyc++;
      if (stall) stall_cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      step();
      start = 1'b0;
      op    = 4'd0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      check({name, "_timeout"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int b0, s0;
      step();
      step();
      chk_en = 1'b1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset_n = 1'b1;

      // mult -3 * 5
      b0 = busy_cyc;
      s0 = stall_cyc;
      issue(4'd1, 32'hFFFF_FFFD, 32'd5);
      wait_idle("mult");
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);
      check("mult_busy_cyc", busy_cyc - b0, 32'd5);
      check("mult_stall_cyc", stall_cyc - s0, 32'd6);

      // multu then mtlo back-to-back
      issue(4'd2, 32'hFFFF_FFFF, 32'd2);
      wait_idle("multu");
      check("multu_hi", hi, 32'h0000_0001);
      check("multu_lo", lo, 32'hFFFF_FFFE);
      issue(4'd6, 32'h1234_5678, 32'd0);
      check("mtlo_lo", lo, 32'h1234_5678);
      check("mtlo_hi", hi, 32'h0000_0001);

      // signed divide
      b0 = busy_cyc;
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle("div");
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      check("div_busy_cyc", busy_cyc - b0, 32'd10);
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("div_ovf");
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'h0000_0000);

      // divide by zero, with a mthi attempted while busy
      issue(4'd5, 32'hAAAA_0000, 32'd0);
      issue(4'd6, 32'h0000_BBBB, 32'd0);
      b0 = busy_cyc;
      issue(4'd4, 32'd7, 32'd0);
      step();
      step();
      step();
      issue(4'd5, 32'd1, 32'd0);
      wait_idle("divu0");
      check("divu0_hi", hi, 32'hAAAA_0000);
      check("divu0_lo", lo, 32'h0000_BBBB);
      check("divu0_busy_cyc", busy_cyc - b0, 32'd10);

      // divu and signed min*min
      issue(4'd4, 32'd100, 32'd7);
      wait_idle("divu");
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);
      issue(4'd1, 32'h8000_0000, 32'h8000_0000);
      wait_idle("mult_min");
      check("mult_min_hi", hi, 32'h4000_0000);
      check("mult_min_lo", lo, 32'd0);

      // operands change during RUN
      issue(4'd1, 32'd3, 32'd4);
      rs_val = 32'd9;
      rt_val = 32'd9;
      wait_idle("mult_chg");
      check("mult_chg_lo", lo, 32'd12);
      check("mult_chg_hi", hi, 32'd0);

      // reset mid-divide with a start held during reset
      issue(4'd3, 32'd100, 32'd7);
      step();
      reset_n = 1'b0;
      start   = 1'b1;
      op      = 4'd1;
      rs_val  = 32'd5;
      rt_val  = 32'd5;
      step();
      reset_n = 1'b1;
      start   = 1'b0;
      op      = 4'd0;
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      for (int i = 0; i < 15; i++) step();
      check("rst_late_busy", {31'b0, busy}, 32'd0);
      check("rst_late_hi", hi, 32'd0);
      check("rst_late_lo", lo, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
